// File: rtl/bcd_ctrl_pkg.sv
// Shared encodings for the keypad-driven BCD counter sequencer: mode commands,
// key codes, edit-position codes, controller states and the digit classifier.
package bcd_ctrl_pkg;

  localparam logic [3:0] MODE_HOLD  = 4'b0000;
  localparam logic [3:0] MODE_CLEAR = 4'b0001;
  localparam logic [3:0] MODE_LOAD  = 4'b0010;
  localparam logic [3:0] MODE_UP    = 4'b0100;
  localparam logic [3:0] MODE_DOWN  = 4'b1000;

  localparam logic [3:0] KEY_EDIT   = 4'hA;
  localparam logic [3:0] KEY_UP     = 4'hB;
  localparam logic [3:0] KEY_DOWN   = 4'hC;
  localparam logic [3:0] KEY_HOLD   = 4'hD;
  localparam logic [3:0] KEY_CLEAR  = 4'hE;
  localparam logic [3:0] KEY_CANCEL = 4'hF;

  localparam logic [1:0] EDIT_POS_NONE  = 2'b00;
  localparam logic [1:0] EDIT_POS_TENS  = 2'b10;
  localparam logic [1:0] EDIT_POS_UNITS = 2'b01;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_EDIT_T,
    ST_EDIT_U,
    ST_LOAD,
    ST_CLEAR
  } ctrl_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/ctrl_hold_timer.sv
// Cycle timer: cleared by start, advances while en, pulses done (combinationally)
// on the cycle its count sits at CYCLES-1. A same-cycle start suppresses done.
module ctrl_hold_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic en,
  output logic done
);

  localparam int unsigned   CW       = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] TERMINAL = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = en && !start && (cnt_q == TERMINAL);
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (en && !done) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Keypad sequencer for the two-digit BCD counter: key events -> registered mode,
// preset and edit status. Optional edit timeout enabled by BCD_CTRL_TIMEOUT_EN.
module bcd_counter_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] mode,
  output logic [7:0] BCD_preset,
  output logic [1:0] edit_pos,
  output logic       busy
);

  if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bcd_counter_ctrl: HOLD_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  ctrl_state_e state_q, state_d;
  logic [3:0]  run_mode_q, run_mode_d;
  logic [7:0]  preset_q, preset_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [3:0]  mode_q, mode_d;
  logic [1:0]  edit_pos_q, edit_pos_d;
  logic        busy_q, busy_d;

  logic in_hold_q, in_hold_d;
  logic hold_start, hold_done;
  logic timeout_done;

  assign in_hold_q  = (state_q == ST_LOAD) || (state_q == ST_CLEAR);
  assign in_hold_d  = (state_d == ST_LOAD) || (state_d == ST_CLEAR);
  assign hold_start = in_hold_d && !in_hold_q;

  ctrl_hold_timer #(
    .CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk_50M),
    .rst_n(rst_n),
    .start(hold_start),
    .en   (in_hold_q),
    .done (hold_done)
  );

`ifdef BCD_CTRL_TIMEOUT_EN
  logic in_edit_q;
  logic timeout_start;

  // Held at zero outside edit, so entering edit always starts from a clean count.
  assign in_edit_q     = (state_q == ST_EDIT_T) || (state_q == ST_EDIT_U);
  assign timeout_start = key_valid || !in_edit_q;

  ctrl_hold_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk  (clk_50M),
    .rst_n(rst_n),
    .start(timeout_start),
    .en   (in_edit_q),
    .done (timeout_done)
  );
`else
  assign timeout_done = 1'b0;
`endif

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      run_mode_q <= MODE_HOLD;
      preset_q   <= '0;
      shadow_q   <= '0;
      mode_q     <= MODE_HOLD;
      edit_pos_q <= EDIT_POS_NONE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_mode_q <= run_mode_d;
      preset_q   <= preset_d;
      shadow_q   <= shadow_d;
      mode_q     <= mode_d;
      edit_pos_q <= edit_pos_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_mode_d = run_mode_q;
    preset_d   = preset_q;
    shadow_d   = shadow_q;
    unique case (state_q)
      ST_RUN: begin
        if (key_valid) begin
          case (key_code)
            KEY_UP:    run_mode_d = MODE_UP;
            KEY_DOWN:  run_mode_d = MODE_DOWN;
            KEY_HOLD:  run_mode_d = MODE_HOLD;
            KEY_EDIT: begin
              shadow_d = preset_q;
              state_d  = ST_EDIT_T;
            end
            KEY_CLEAR: state_d = ST_CLEAR;
            default: ;
          endcase
        end
      end
      ST_EDIT_T, ST_EDIT_U: begin
        if (key_valid && is_digit(key_code)) begin
          if (state_q == ST_EDIT_T) begin
            preset_d[7:4] = key_code;
            state_d       = ST_EDIT_U;
          end else begin
            preset_d[3:0] = key_code;
            state_d       = ST_LOAD;
          end
        end else if ((key_valid && key_code == KEY_CANCEL) || (!key_valid && timeout_done)) begin
          preset_d = shadow_q;
          state_d  = ST_RUN;
        end
      end
      ST_LOAD, ST_CLEAR: begin
        if (hold_done) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs decode the next state so they are registered alongside it.
  always_comb begin
    mode_d     = MODE_HOLD;
    edit_pos_d = EDIT_POS_NONE;
    busy_d     = 1'b0;
    unique case (state_d)
      ST_RUN:    mode_d = run_mode_d;
      ST_EDIT_T: edit_pos_d = EDIT_POS_TENS;
      ST_EDIT_U: edit_pos_d = EDIT_POS_UNITS;
      ST_LOAD: begin
        mode_d = MODE_LOAD;
        busy_d = 1'b1;
      end
      ST_CLEAR: begin
        mode_d = MODE_CLEAR;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign mode       = mode_q;
  assign BCD_preset = preset_q;
  assign edit_pos   = edit_pos_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Bench for bcd_counter_ctrl: directed scenarios plus random key traffic, all
// compared against a cycle-level behavioural model of the keypad sequencer.
module tb_bcd_counter_ctrl;

  localparam int unsigned HOLD = 4;
  localparam int unsigned TMO  = 8;
`ifdef BCD_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] mode;
  logic [7:0] BCD_preset;
  logic [1:0] edit_pos;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  bcd_counter_ctrl #(
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_50M   (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .mode      (mode),
    .BCD_preset(BCD_preset),
    .edit_pos  (edit_pos),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Model: edit digits pending (0 none, 1 tens, 2 units), hold cycles remaining.
  logic [3:0] m_run_mode;
  logic [7:0] m_preset;
  logic [7:0] m_shadow;
  int         m_hold_left;
  bit         m_hold_clear;
  int         m_edit;
  int         m_idle;

  task automatic model_reset();
    m_run_mode = 4'b0000; m_preset = 8'h00; m_shadow = 8'h00;
    m_hold_left = 0; m_hold_clear = 1'b0; m_edit = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit kv, input logic [3:0] kc);
    if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (m_edit > 0) begin
      if (kv) begin
        m_idle = 0;
        if (kc <= 4'd9) begin
          if (m_edit == 1) begin
            m_preset = {kc, m_preset[3:0]};
            m_edit = 2;
          end else begin
            m_preset = {m_preset[7:4], kc};
            m_edit = 0;
            m_hold_left = HOLD;
            m_hold_clear = 1'b0;
          end
        end else if (kc == 4'hF) begin
          m_preset = m_shadow;
          m_edit = 0;
        end
      end else begin
        m_idle++;
        if (TO_EN && m_idle == TMO) begin
          m_preset = m_shadow;
          m_edit = 0;
        end
      end
    end else if (kv) begin
      case (kc)
        4'hB: m_run_mode = 4'b0100;
        4'hC: m_run_mode = 4'b1000;
        4'hD: m_run_mode = 4'b0000;
        4'hA: begin m_shadow = m_preset; m_edit = 1; m_idle = 0; end
        4'hE: begin m_hold_left = HOLD; m_hold_clear = 1'b1; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [14:0] expected();
    logic [3:0] md;
    logic [1:0] ep;
    if (m_hold_left > 0) md = m_hold_clear ? 4'b0001 : 4'b0010;
    else if (m_edit > 0) md = 4'b0000;
    else md = m_run_mode;
    ep = (m_edit == 1) ? 2'b10 : (m_edit == 2) ? 2'b01 : 2'b00;
    return {md, m_preset, ep, (m_hold_left > 0)};
  endfunction

  function automatic logic [14:0] observed();
    return {mode, BCD_preset, edit_pos, busy};
  endfunction

  task automatic tick(input bit kv, input logic [3:0] kc);
    @(negedge clk);
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    if (rst_n) model_step(kv, kc);
    else model_reset();
    #1;
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b0, 4'h0);
    tick(1'b1, 4'hB);
    checks++;
    if (observed() !== 15'h0) begin
      failures++;
      $display("FAIL reset_state: got %h want %h", observed(), 15'h0);
    end
    rst_n = 1'b1;
    tick(1'b1, 4'hA); tick(1'b1, 4'h4); tick(1'b1, 4'h7);
    tick(1'b0, 4'h0); tick(1'b0, 4'h0);
    checks++;
    if (mode !== 4'b0010 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload: got mode=%b busy=%b want 0010/1", mode, busy);
    end
    rst_n = 1'b0;
    tick(1'b0, 4'h0);
    checks++;
    if (observed() !== 15'h0) begin
      failures++;
      $display("FAIL reset_mid_load: got %h want %h", observed(), 15'h0);
    end
    rst_n = 1'b1;
    tick(1'b0, 4'h0);
    checks++;
    if (observed() !== expected()) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_run_modes();
    logic [3:0] keys[3] = '{4'hB, 4'hC, 4'hD};
    logic [3:0] want[3] = '{4'b0100, 4'b1000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, keys[i]);
      checks++;
      if (mode !== want[i] || observed() !== expected()) begin
        failures++;
        $display("FAIL run_mode_%0d: got %h want mode=%b model=%h", i, observed(), want[i], expected());
      end
    end
  endtask

  task automatic test_load();
    logic [3:0] keys[4] = '{4'hB, 4'hA, 4'h4, 4'h7};
    logic [1:0] want_ep[4] = '{2'b00, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, keys[i]);
      checks++;
      if (edit_pos !== want_ep[i] || observed() !== expected()) begin
        failures++;
        $display("FAIL load_key_%0d: got %h want edit_pos=%b model=%h", i, observed(), want_ep[i], expected());
      end
    end
    checks++;
    if (BCD_preset !== 8'h47 || mode !== 4'b0010 || busy !== 1'b1) begin
      failures++;
      $display("FAIL load_entry: got preset=%h mode=%b busy=%b want 47/0010/1", BCD_preset, mode, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 4'h0);
      checks++;
      if (mode !== ((i < 3) ? 4'b0010 : 4'b0100) || observed() !== expected()) begin
        failures++;
        $display("FAIL load_hold_%0d: got %h want %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_cancel();
    tick(1'b1, 4'hA);
    tick(1'b1, 4'h2);
    checks++;
    if (BCD_preset !== 8'h27 || edit_pos !== 2'b01 || mode !== 4'b0000) begin
      failures++;
      $display("FAIL cancel_tens: got preset=%h edit_pos=%b mode=%b want 27/01/0000", BCD_preset, edit_pos, mode);
    end
    tick(1'b1, 4'hF);
    checks++;
    if (BCD_preset !== 8'h47 || edit_pos !== 2'b00 || mode !== 4'b0100 || observed() !== expected()) begin
      failures++;
      $display("FAIL cancel_restore: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_clear();
    logic [3:0] keys[3] = '{4'hB, 4'hA, 4'h5};
    tick(1'b1, 4'hC);
    tick(1'b1, 4'hE);
    checks++;
    if (mode !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_entry: got mode=%b busy=%b want 0001/1", mode, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, keys[i]);
      checks++;
      if (mode !== 4'b0001 || busy !== 1'b1 || edit_pos !== 2'b00 || observed() !== expected()) begin
        failures++;
        $display("FAIL clear_drop_%0d: got %h want %h", i, observed(), expected());
      end
    end
    tick(1'b0, 4'h0);
    checks++;
    if (mode !== 4'b1000 || busy !== 1'b0 || BCD_preset !== 8'h47 || observed() !== expected()) begin
      failures++;
      $display("FAIL clear_exit: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_edit_idle();
    tick(1'b1, 4'hA);
    tick(1'b1, 4'h3);
`ifdef BCD_CTRL_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 4'h0);
      checks++;
      if (edit_pos !== ((i < 8) ? 2'b01 : 2'b00) || observed() !== expected()) begin
        failures++;
        $display("FAIL timeout_idle_%0d: got %h want %h", i, observed(), expected());
      end
    end
    checks++;
    if (BCD_preset !== 8'h47) begin
      failures++;
      $display("FAIL timeout_restore: got %h want 47", BCD_preset);
    end
    tick(1'b1, 4'hA);
    tick(1'b1, 4'h3);
    for (int i = 1; i < 8; i++) tick(1'b0, 4'h0);
    tick(1'b1, 4'h5);
    checks++;
    if (BCD_preset !== 8'h35 || mode !== 4'b0010 || observed() !== expected()) begin
      failures++;
      $display("FAIL timeout_key_wins: got %h want %h", observed(), expected());
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h0);
`else
    for (int i = 1; i <= 12; i++) tick(1'b0, 4'h0);
    checks++;
    if (edit_pos !== 2'b01 || BCD_preset !== 8'h37 || observed() !== expected()) begin
      failures++;
      $display("FAIL edit_persists: got %h want %h", observed(), expected());
    end
    tick(1'b1, 4'hF);
`endif
    checks++;
    if (observed() !== expected()) begin
      failures++;
      $display("FAIL edit_idle_exit: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_random();
    bit         kv;
    logic [3:0] kc;
    for (int i = 0; i < 600; i++) begin
      kv = ($urandom_range(0, 2) == 0);
      kc = 4'($urandom_range(0, 15));
      tick(kv, kc);
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("FAIL random_%0d: key=%b/%h got %h want %h", i, kv, kc, observed(), expected());
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    model_reset();
    test_reset();
    test_run_modes();
    test_load();
    test_cancel();
    test_clear();
    test_edit_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
